i2c_master_byte_ctrl: RTL and testbench

Byte-level I2C master controller that sits directly upstream of the I2C master bit PHY. It accepts one byte transaction at a time over a valid/ready interface and sequences the PHY's bit commands: optional START, 8 data bits MSB first, an ACK bit, and optional STOP. It returns the read byte and the slave ACK, and aborts cleanly on arbitration loss.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_master_byte_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_master_byte_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: PHY bit commands, byte-controller states and ACK levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        BIT_NOP   = 3'd0,
        BIT_START = 3'd1,
        BIT_STOP  = 3'd2,
        BIT_READ  = 3'd3,
        BIT_WRITE = 3'd4
    } bit_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_STOP,
        ST_ABORT
    } byte_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: sequences START / 8 data bits / ACK / STOP on the bit PHY.
// Build option I2C_NACK_AUTOSTOP_EN: a NACKed write without STOP still issues STOP.
module i2c_master_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int BUS_WAIT_LIMIT = 0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_start_i,
    input  logic       cmd_stop_i,
    input  logic       cmd_read_i,
    input  logic       cmd_ack_i,
    input  logic [7:0] wr_data_i,
    output logic       done_o,
    output logic [7:0] rd_data_o,
    output logic       rx_ack_o,
    output logic       arb_lost_o,
    output logic       timeout_o,
    output logic [2:0] phy_cmd_o,
    output logic       phy_data_o,
    input  logic       phy_data_i,
    input  logic       phy_cmd_done_i,
    input  logic       phy_arb_lost_i,
    input  logic       phy_bus_busy_i
);

    localparam logic [15:0] WAIT_LIM = 16'(BUS_WAIT_LIMIT);
    localparam bit          WAIT_EN  = (BUS_WAIT_LIMIT != 0);

    byte_state_e state_q, state_d;
    bit_cmd_e    phy_cmd_q, cmd_d;
    logic        phy_data_q, pdata_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        read_q, read_d;
    logic        stop_q, stop_d;
    logic        ack_q, ack_d;
    logic        owned_q, owned_d;
    logic        inflight_q, inflight_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        done_q, done_d;
    logic        arb_q, arb_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rx_ack_q, rx_ack_d;
    logic        nack_stop;

`ifdef I2C_NACK_AUTOSTOP_EN
    assign nack_stop = !read_q && (phy_data_i == I2C_NACK);
`else
    assign nack_stop = 1'b0;
`endif

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign phy_cmd_o   = phy_cmd_q;
    assign phy_data_o  = phy_data_q;
    assign done_o      = done_q;
    assign arb_lost_o  = arb_q;
    assign timeout_o   = tmo_q;
    assign rd_data_o   = rd_data_q;
    assign rx_ack_o    = rx_ack_q;

    always_comb begin
        state_d    = state_q;
        cmd_d      = phy_cmd_q;
        pdata_d    = phy_data_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        read_d     = read_q;
        stop_d     = stop_q;
        ack_d      = ack_q;
        owned_d    = owned_q;
        inflight_d = inflight_q;
        wait_cnt_d = wait_cnt_q;
        done_d     = 1'b0;
        arb_d      = 1'b0;
        tmo_d      = 1'b0;
        rd_data_d  = rd_data_q;
        rx_ack_d   = rx_ack_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_d   = BIT_NOP;
                pdata_d = 1'b1;
                if (cmd_valid_i) begin
                    read_d     = cmd_read_i;
                    stop_d     = cmd_stop_i;
                    ack_d      = cmd_ack_i;
                    shreg_d    = wr_data_i;
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    if (cmd_start_i) begin
                        state_d = ST_WAIT_BUS;
                    end else begin
                        state_d = ST_DATA;
                        cmd_d   = cmd_read_i ? BIT_READ : BIT_WRITE;
                        pdata_d = cmd_read_i | wr_data_i[7];
                    end
                end
            end
            ST_WAIT_BUS: begin
                // A bus we already own is busy only because of us: repeated START goes ahead.
                if (!phy_bus_busy_i || owned_q) begin
                    state_d = ST_START;
                    cmd_d   = BIT_START;
                    pdata_d = 1'b1;
                end else if (WAIT_EN && wait_cnt_q == WAIT_LIM) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_START: begin
                if (phy_cmd_done_i) begin
                    owned_d = 1'b1;
                    state_d = ST_DATA;
                    cmd_d   = read_q ? BIT_READ : BIT_WRITE;
                    pdata_d = read_q | shreg_q[7];
                end
            end
            ST_DATA: begin
                if (phy_cmd_done_i) begin
                    shreg_d   = {shreg_q[6:0], phy_data_i};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_ACK;
                        cmd_d   = read_q ? BIT_WRITE : BIT_READ;
                        pdata_d = read_q ? ack_q : 1'b1;
                    end else begin
                        pdata_d = read_q | shreg_q[6];
                    end
                end
            end
            ST_ACK: begin
                if (phy_cmd_done_i) begin
                    if (read_q) rd_data_d = shreg_q;
                    else        rx_ack_d  = phy_data_i;
                    pdata_d = 1'b1;
                    if (stop_q || nack_stop) begin
                        state_d = ST_STOP;
                        cmd_d   = BIT_STOP;
                    end else begin
                        state_d = ST_IDLE;
                        cmd_d   = BIT_NOP;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (phy_cmd_done_i) begin
                    owned_d = 1'b0;
                    state_d = ST_IDLE;
                    cmd_d   = BIT_NOP;
                    done_d  = 1'b1;
                end
            end
            ST_ABORT: begin
                cmd_d   = BIT_NOP;
                pdata_d = 1'b1;
                if (!inflight_q || phy_cmd_done_i) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    arb_d      = 1'b1;
                    owned_d    = 1'b0;
                    inflight_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Arbitration loss overrides whatever the state decided this cycle.
        if (phy_arb_lost_i && state_q != ST_IDLE && state_q != ST_ABORT) begin
            cmd_d     = BIT_NOP;
            pdata_d   = 1'b1;
            tmo_d     = 1'b0;
            rd_data_d = rd_data_q;
            rx_ack_d  = rx_ack_q;
            if (phy_cmd_done_i) begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                arb_d      = 1'b1;
                owned_d    = 1'b0;
                inflight_d = 1'b0;
            end else begin
                state_d    = ST_ABORT;
                done_d     = 1'b0;
                inflight_d = (phy_cmd_q != BIT_NOP);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            phy_cmd_q  <= BIT_NOP;
            phy_data_q <= 1'b1;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            read_q     <= 1'b0;
            stop_q     <= 1'b0;
            ack_q      <= 1'b1;
            owned_q    <= 1'b0;
            inflight_q <= 1'b0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
            arb_q      <= 1'b0;
            tmo_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rx_ack_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            phy_cmd_q  <= cmd_d;
            phy_data_q <= pdata_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            read_q     <= read_d;
            stop_q     <= stop_d;
            ack_q      <= ack_d;
            owned_q    <= owned_d;
            inflight_q <= inflight_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
            arb_q      <= arb_d;
            tmo_q      <= tmo_d;
            rd_data_q  <= rd_data_d;
            rx_ack_q   <= rx_ack_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Scoreboard bench for i2c_master_byte_ctrl: a PHY stub checks each bit command, a monitor checks each done.
`timescale 1ns/1ps
module tb_i2c_master_byte_ctrl;
    import i2c_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       cmd_valid_i = 1'b0, cmd_start_i = 1'b0, cmd_stop_i = 1'b0;
    logic       cmd_read_i = 1'b0, cmd_ack_i = 1'b0;
    logic [7:0] wr_data_i = 8'h00;
    logic       cmd_ready_o, done_o, rx_ack_o, arb_lost_o, timeout_o, phy_data_o;
    logic [7:0] rd_data_o;
    logic [2:0] phy_cmd_o;
    logic       phy_data_i = 1'b1, phy_cmd_done_i = 1'b0;
    logic       phy_arb_lost_i = 1'b0, phy_bus_busy_i = 1'b0;

    always #5 clk_i = ~clk_i;

    i2c_master_byte_ctrl #(.BUS_WAIT_LIMIT(100)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_start_i(cmd_start_i), .cmd_stop_i(cmd_stop_i),
        .cmd_read_i(cmd_read_i), .cmd_ack_i(cmd_ack_i), .wr_data_i(wr_data_i),
        .done_o(done_o), .rd_data_o(rd_data_o), .rx_ack_o(rx_ack_o),
        .arb_lost_o(arb_lost_o), .timeout_o(timeout_o),
        .phy_cmd_o(phy_cmd_o), .phy_data_o(phy_data_o), .phy_data_i(phy_data_i),
        .phy_cmd_done_i(phy_cmd_done_i), .phy_arb_lost_i(phy_arb_lost_i),
        .phy_bus_busy_i(phy_bus_busy_i)
    );

    typedef struct packed { logic [2:0] cmd; logic dat; } phy_exp_t;
    typedef struct packed { logic arb; logic tmo; logic rx_ack; logic [7:0] rd; } done_exp_t;

    phy_exp_t   exp_phy[$];
    done_exp_t  exp_done[$];
    logic       rd_bits[$];
    int         checks = 0, failures = 0;
    int         n_done = 0;
    logic       active = 1'b0;
    logic [2:0] cur_cmd = 3'd0;
    logic       cur_dat = 1'b1;
    int         cnt = 0;
    phy_exp_t   pe;
    done_exp_t  de;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // PHY stub + done monitor: every bit takes 2 cycles; a latched bit completes even if the DUT drops to NOP.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            phy_cmd_done_i = 1'b0;
            active = 1'b0;
        end else begin
            if (done_o) begin
                if (exp_done.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got arb=%0b tmo=%0b, no done expected", arb_lost_o, timeout_o);
                end else begin
                    de = exp_done.pop_front();
                    check("done_arb_lost", 32'(arb_lost_o), 32'(de.arb));
                    check("done_timeout", 32'(timeout_o), 32'(de.tmo));
                    check("done_rx_ack", 32'(rx_ack_o), 32'(de.rx_ack));
                    check("done_rd_data", 32'(rd_data_o), 32'(de.rd));
                end
            end
            if (phy_cmd_done_i) begin
                phy_cmd_done_i = 1'b0;
                active = 1'b0;
            end
            if (!active && phy_cmd_o != BIT_NOP) begin
                active  = 1'b1;
                cur_cmd = phy_cmd_o;
                cur_dat = phy_data_o;
                cnt     = 0;
            end else if (active) begin
                cnt++;
                if (cnt == 2) begin
                    if (cur_cmd == BIT_READ)
                        phy_data_i = (rd_bits.size() != 0) ? rd_bits.pop_front() : 1'b1;
                    if (exp_phy.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_phy_cmd: got cmd %0d, none expected", cur_cmd);
                    end else begin
                        pe = exp_phy.pop_front();
                        check("phy_cmd", 32'(cur_cmd), 32'(pe.cmd));
                        if (pe.cmd == BIT_WRITE) check("phy_write_data", 32'(cur_dat), 32'(pe.dat));
                    end
                    phy_cmd_done_i = 1'b1;
                    n_done++;
                end
            end
        end
    end

    task automatic exp_cmd(input bit_cmd_e c, input logic d);
        exp_phy.push_back('{cmd: c, dat: d});
    endtask

    task automatic exp_wbyte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_cmd(BIT_WRITE, b[i]);
    endtask

    task automatic slave_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) rd_bits.push_back(b[i]);
    endtask

    task automatic exp_result(input logic arb, input logic tmo, input logic rxa, input logic [7:0] rd);
        exp_done.push_back('{arb: arb, tmo: tmo, rx_ack: rxa, rd: rd});
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic s, input logic p, input logic r, input logic a, input logic [7:0] d);
        int k;
        k = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && k < 1000) begin @(negedge clk_i); k++; end
        if (!cmd_ready_o) begin
            checks++; failures++;
            $display("FAIL send_ready: cmd_ready_o stayed %0b, required 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_start_i = s; cmd_stop_i = p;
        cmd_read_i = r; cmd_ack_i = a; wr_data_i = d;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_done.size() != 0 || exp_phy.size() != 0) && k < 2000) begin
            @(posedge clk_i); k++;
        end
        check(name, 32'(exp_done.size() + exp_phy.size()), 32'd0);
        @(negedge clk_i);
    endtask

    task automatic wait_bits(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 500) begin @(posedge clk_i); k++; end
        check("wait_bits", 32'(n_done >= target), 32'd1);
    endtask

    initial begin
        int base, k;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_phy_cmd", 32'(phy_cmd_o), 32'(BIT_NOP));
        check("rst_phy_data", 32'(phy_data_o), 32'd1);
        check("rst_done", 32'({done_o, arb_lost_o, timeout_o}), 32'd0);
        check("rst_rd_data", 32'(rd_data_o), 32'h00);
        check("rst_rx_ack", 32'(rx_ack_o), 32'd1);
        @(negedge clk_i) rst_n_i = 1'b1;

        // START + write 0xA5, slave ACKs
        exp_cmd(BIT_START, 1'b1); exp_wbyte(8'hA5); exp_cmd(BIT_READ, 1'b1);
        rd_bits.push_back(1'b0);
        exp_result(1'b0, 1'b0, 1'b0, 8'h00);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        check("wait_bus_nop", 32'(phy_cmd_o), 32'(BIT_NOP));
        @(posedge clk_i); #1;
        check("start_latency", 32'(phy_cmd_o), 32'(BIT_START));
        wait_drain("drain_write_a5");

        // read 0x3C, master NACKs, then STOP
        repeat (8) exp_cmd(BIT_READ, 1'b1);
        exp_cmd(BIT_WRITE, 1'b1); exp_cmd(BIT_STOP, 1'b1);
        slave_byte(8'h3C);
        exp_result(1'b0, 1'b0, 1'b0, 8'h3C);
        send(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check("read_latency", 32'(phy_cmd_o), 32'(BIT_READ));
        wait_drain("drain_read_3c");

        // arbitration loss during data bit 3 of a write
        base = n_done;
        exp_cmd(BIT_START, 1'b1); exp_cmd(BIT_WRITE, 1'b1);
        exp_cmd(BIT_WRITE, 1'b0); exp_cmd(BIT_WRITE, 1'b0);
        exp_result(1'b1, 1'b0, 1'b0, 8'h3C);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h96);
        wait_bits(base + 3);
        @(negedge clk_i) phy_arb_lost_i = 1'b1;
        @(posedge clk_i); #1;
        phy_arb_lost_i = 1'b0;
        check("abort_nop", 32'(phy_cmd_o), 32'(BIT_NOP));
        check("abort_no_early_done", 32'(done_o), 32'd0);
        wait_drain("drain_arb");

        // bus no longer owned: START must wait for the busy bus
        phy_bus_busy_i = 1'b1;
        exp_cmd(BIT_START, 1'b1); exp_wbyte(8'h01); exp_cmd(BIT_READ, 1'b1); exp_cmd(BIT_STOP, 1'b1);
        rd_bits.push_back(1'b1);
        exp_result(1'b0, 1'b0, 1'b1, 8'h3C);
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        repeat (10) @(posedge clk_i);
        #1;
        check("busy_hold_nop", 32'(phy_cmd_o), 32'(BIT_NOP));
        check("busy_hold_not_ready", 32'(cmd_ready_o), 32'd0);
        @(negedge clk_i) phy_bus_busy_i = 1'b0;
        wait_drain("drain_after_busy");

        // busy bus times out after 101 cycles, no PHY command
        phy_bus_busy_i = 1'b1;
        exp_result(1'b0, 1'b1, 1'b1, 8'h3C);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        k = 0;
        while (!done_o && k < 150) begin @(posedge clk_i); #1; k++; end
        check("timeout_cycles", 32'(k), 32'd101);
        wait_drain("drain_timeout");

        // take the bus, then a repeated START while busy goes through at once
        phy_bus_busy_i = 1'b0;
        exp_cmd(BIT_START, 1'b1); exp_wbyte(8'h22); exp_cmd(BIT_READ, 1'b1);
        rd_bits.push_back(1'b0);
        exp_result(1'b0, 1'b0, 1'b0, 8'h3C);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        wait_drain("drain_write_22");
        phy_bus_busy_i = 1'b1;
        exp_cmd(BIT_START, 1'b1); exp_wbyte(8'h33); exp_cmd(BIT_READ, 1'b1); exp_cmd(BIT_STOP, 1'b1);
        rd_bits.push_back(1'b0);
        exp_result(1'b0, 1'b0, 1'b0, 8'h3C);
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        @(posedge clk_i); #1;
        check("rep_start_latency", 32'(phy_cmd_o), 32'(BIT_START));
        wait_drain("drain_rep_start");
        phy_bus_busy_i = 1'b0;

        // write 0x50 without STOP, slave NACKs
        exp_cmd(BIT_START, 1'b1); exp_wbyte(8'h50); exp_cmd(BIT_READ, 1'b1);
`ifdef I2C_NACK_AUTOSTOP_EN
        exp_cmd(BIT_STOP, 1'b1);
`endif
        rd_bits.push_back(1'b1);
        exp_result(1'b0, 1'b0, 1'b1, 8'h3C);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h50);
        wait_drain("drain_nack_50");
        repeat (8) @(posedge clk_i);

        // reset during data bit 5
        base = n_done;
        exp_cmd(BIT_START, 1'b1); exp_wbyte(8'hC3); exp_cmd(BIT_READ, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
        wait_bits(base + 5);
        @(negedge clk_i) rst_n_i = 1'b0;
        #1;
        exp_phy.delete(); exp_done.delete(); rd_bits.delete();
        check("midrst_phy_cmd", 32'(phy_cmd_o), 32'(BIT_NOP));
        check("midrst_phy_data", 32'(phy_data_o), 32'd1);
        check("midrst_done", 32'({done_o, arb_lost_o, timeout_o}), 32'd0);
        check("midrst_rd_data", 32'(rd_data_o), 32'h00);
        check("midrst_rx_ack", 32'(rx_ack_o), 32'd1);
        check("midrst_ready", 32'(cmd_ready_o), 32'd1);
        @(negedge clk_i) rst_n_i = 1'b1;

        exp_cmd(BIT_START, 1'b1); exp_wbyte(8'hFF); exp_cmd(BIT_READ, 1'b1); exp_cmd(BIT_STOP, 1'b1);
        rd_bits.push_back(1'b0);
        exp_result(1'b0, 1'b0, 1'b0, 8'h00);
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        wait_drain("drain_write_ff");
        repeat (8) @(posedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
